// File: rtl/hilo_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_mult_unit
//  Purpose  : Iterative MULT/MULTU/MADD/MSUB unit owning the HI/LO registers,
//             with MTHI/MTLO writes and MFHI/MFLO reads (stall on busy).
//  Config   : HILO_BYPASS_EN forwards the FIX-stage result to MFHI/MFLO.
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_mult_unit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Valid,
    input  logic [5:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Ready,
    output logic        Stall,
    output logic [31:0] HiLoOut,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int         c_N          = 32 / BITS_PER_CYCLE;
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CALC    = 2'd1;
    localparam logic [1:0] c_ST_FIX     = 2'd2;
    localparam logic [5:0] c_OP_MULTU   = 6'b000100;
    localparam logic [5:0] c_OP_MULT    = 6'b100100;
    localparam logic [5:0] c_OP_MADD    = 6'b000101;
    localparam logic [5:0] c_OP_MSUB    = 6'b100101;
    localparam logic [5:0] c_OP_MTHI    = 6'b001101;
    localparam logic [5:0] c_OP_MTLO    = 6'b101101;
    localparam logic [5:0] c_OP_MFHI    = 6'b001110;
    localparam logic [5:0] c_OP_MFLO    = 6'b101110;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_prod;
    logic [63:0] r_mcand;
    logic [32:0] r_mplier;
    logic        r_sign;
    logic [5:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mult;
    logic        w_signed_op;
    logic [32:0] w_a_ext;
    logic [32:0] w_b_ext;
    logic [32:0] w_mag_a;
    logic [32:0] w_mag_b;
    logic [63:0] w_addend;
    logic [63:0] w_p;
    logic [63:0] w_commit;
    logic        w_is_mfhi;
    logic        w_is_mflo;
    logic        w_rd_ok;
    logic [63:0] w_rd_val;

    assign w_is_mult   = (ALUControl == c_OP_MULTU) || (ALUControl == c_OP_MULT) ||
                         (ALUControl == c_OP_MADD)  || (ALUControl == c_OP_MSUB);
    assign w_signed_op = (ALUControl != c_OP_MULTU);

    // 33-bit magnitudes so that -2^31 becomes +2^31 without overflow
    assign w_a_ext = {w_signed_op & A[31], A};
    assign w_b_ext = {w_signed_op & B[31], B};
    assign w_mag_a = w_a_ext[32] ? (~w_a_ext + 33'd1) : w_a_ext;
    assign w_mag_b = w_b_ext[32] ? (~w_b_ext + 33'd1) : w_b_ext;

    always_comb begin
        w_addend = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_addend = w_addend + (r_mcand << i);
            end
        end
    end

    assign w_p = r_sign ? (64'd0 - r_prod) : r_prod;

    always_comb begin
        case (r_op)
            c_OP_MADD: w_commit = {r_hi, r_lo} + w_p;
            c_OP_MSUB: w_commit = {r_hi, r_lo} - w_p;
            default:   w_commit = w_p;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (Valid) begin
                        if (w_is_mult) begin
                            r_mcand  <= {31'd0, w_mag_a};
                            r_mplier <= w_mag_b;
                            r_sign   <= w_signed_op & (A[31] ^ B[31]);
                            r_op     <= ALUControl;
                            r_prod   <= '0;
                            r_cnt    <= 5'(c_N - 1);
                            r_state  <= c_ST_CALC;
                        end else if (ALUControl == c_OP_MTHI) begin
                            r_hi <= A;
                        end else if (ALUControl == c_OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                c_ST_CALC: begin
                    r_prod   <= r_prod + w_addend;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    if (r_cnt == 5'd0) begin
                        r_state <= c_ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                c_ST_FIX: begin
                    {r_hi, r_lo} <= w_commit;
                    r_state      <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_is_mfhi = Valid && (ALUControl == c_OP_MFHI);
    assign w_is_mflo = Valid && (ALUControl == c_OP_MFLO);

`ifdef HILO_BYPASS_EN
    // In FIX the adder output is the value about to land in HI/LO
    assign w_rd_ok  = (r_state == c_ST_IDLE) || (r_state == c_ST_FIX);
    assign w_rd_val = (r_state == c_ST_FIX) ? w_commit : {r_hi, r_lo};
`else
    assign w_rd_ok  = (r_state == c_ST_IDLE);
    assign w_rd_val = {r_hi, r_lo};
`endif

    assign Ready   = (r_state == c_ST_IDLE);
    assign Stall   = (w_is_mfhi || w_is_mflo) && !w_rd_ok;
    assign HiLoOut = (w_rd_ok && w_is_mfhi) ? w_rd_val[63:32] :
                     (w_rd_ok && w_is_mflo) ? w_rd_val[31:0]  : 32'd0;
    assign Hi      = r_hi;
    assign Lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_mult_unit
//  Purpose  : Self-checking bench; four units (1/2/4/8 bits per cycle) share
//             stimulus and are compared against a 64-bit arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_mult_unit;

    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MULT  = 6'b100100;
    localparam logic [5:0] OP_MADD  = 6'b000101;
    localparam logic [5:0] OP_MSUB  = 6'b100101;
    localparam logic [5:0] OP_MTHI  = 6'b001101;
    localparam logic [5:0] OP_MTLO  = 6'b101101;
    localparam logic [5:0] OP_MFHI  = 6'b001110;
    localparam logic [5:0] OP_MFLO  = 6'b101110;
    localparam logic [5:0] OP_BAD   = 6'b111111;
`ifdef HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Rst;
    logic             Valid;
    logic [5:0]       ALUControl;
    logic [31:0]      A;
    logic [31:0]      B;
    logic [3:0]       rdy;
    logic [3:0]       stl;
    logic [3:0][31:0] hlo;
    logic [3:0][31:0] hi;
    logic [3:0][31:0] lo;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hilo_mult_unit #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .Clk        (Clk),
            .Rst        (Rst),
            .Valid      (Valid),
            .ALUControl (ALUControl),
            .A          (A),
            .B          (B),
            .Ready      (rdy[g]),
            .Stall      (stl[g]),
            .HiLoOut    (hlo[g]),
            .Hi         (hi[g]),
            .Lo         (lo[g])
        );
    end

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] m_hilo;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] mprod(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (op == OP_MULTU) return {32'd0, a} * {32'd0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic bit is_mult(input logic [5:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_MADD || op == OP_MSUB;
    endfunction

    task automatic model_apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_MULT, OP_MULTU: m_hilo = mprod(op, a, b);
            OP_MADD:           m_hilo = m_hilo + mprod(op, a, b);
            OP_MSUB:           m_hilo = m_hilo - mprod(op, a, b);
            OP_MTHI:           m_hilo[63:32] = a;
            OP_MTLO:           m_hilo[31:0]  = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; issues one op, waits for every unit to be idle.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat[4];
        bit all;
        ALUControl = op; A = a; B = b; Valid = 1'b1;
        @(negedge Clk);
        Valid = 1'b0;
        model_apply(op, a, b);
        for (int k = 0; k < 4; k++) lat[k] = -1;
        for (int c = 0; c <= 40; c++) begin
            all = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (lat[k] < 0 && rdy[k]) lat[k] = c;
                if (lat[k] < 0) all = 1'b0;
            end
            if (all) break;
            @(negedge Clk);
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("latency[bpc=%0d]", 1 << k), 64'(lat[k]),
                is_mult(op) ? 64'((32 >> k) + 1) : 64'd0);
            chk($sformatf("hilo[bpc=%0d] op=%b", 1 << k, op), {hi[k], lo[k]}, m_hilo);
        end
    endtask

    task automatic do_read(input logic [5:0] op);
        logic [31:0] exp;
        exp = (op == OP_MFHI) ? m_hilo[63:32] : (op == OP_MFLO) ? m_hilo[31:0] : 32'd0;
        ALUControl = op; Valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("read[bpc=%0d] op=%b", 1 << k, op), 64'(hlo[k]), 64'(exp));
            chk($sformatf("read_stall[bpc=%0d]", 1 << k), 64'(stl[k]), 64'd0);
        end
        @(negedge Clk);
        Valid = 1'b0;
        for (int k = 0; k < 4; k++)
            chk($sformatf("read_keeps_hilo[bpc=%0d]", 1 << k), {hi[k], lo[k]}, m_hilo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[3] = '{OP_MTHI,  32'd0,        32'd0,        32'd0,        32'd0};
        tbl[4] = '{OP_MTLO,  32'd10,       32'd0,        32'd0,        32'd10};
        tbl[5] = '{OP_MADD,  32'd3,        32'd4,        32'd0,        32'd22};
        tbl[6] = '{OP_MSUB,  32'hFFFFFFFF, 32'd30,       32'd0,        32'd52};

        Rst = 1'b1; Valid = 1'b0; ALUControl = '0; A = '0; B = '0;
        m_hilo = '0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_ready[%0d]", k), 64'(rdy[k]), 64'd1);
            chk($sformatf("rst_stall[%0d]", k), 64'(stl[k]), 64'd0);
            chk($sformatf("rst_hiloout[%0d]", k), 64'(hlo[k]), 64'd0);
            chk($sformatf("rst_hilo[%0d]", k), {hi[k], lo[k]}, 64'd0);
        end

        // Directed vector table, issued back-to-back
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b);
            for (int k = 0; k < 4; k++)
                chk($sformatf("vec%0d[bpc=%0d]", i, 1 << k), {hi[k], lo[k]},
                    {tbl[i].exp_hi, tbl[i].exp_lo});
        end

        // Read-while-busy: MULT 7,6, an ignored MTLO 9, then MFLO held
        ALUControl = OP_MULT; A = 32'd7; B = 32'd6; Valid = 1'b1;
        @(negedge Clk);
        ALUControl = OP_MTLO; A = 32'd9;
        @(negedge Clk);
        ALUControl = OP_MFLO;
        for (int c = 1; c <= 34; c++) begin
            #1;
            for (int k = 0; k < 4; k++) begin
                int  n;
                bit  ok;
                n  = 32 >> k;
                ok = (c >= n + 1) || (BYP && c == n);
                chk($sformatf("busy_stall[bpc=%0d,c=%0d]", 1 << k, c), 64'(stl[k]), 64'(!ok));
                chk($sformatf("busy_read[bpc=%0d,c=%0d]", 1 << k, c), 64'(hlo[k]),
                    ok ? 64'd42 : 64'd0);
            end
            @(negedge Clk);
        end
        Valid = 1'b0;
        m_hilo = 64'd42;
        for (int k = 0; k < 4; k++)
            chk($sformatf("mtlo_ignored[bpc=%0d]", 1 << k), {hi[k], lo[k]}, 64'd42);

        // Reset in the middle of MULT 100,100
        ALUControl = OP_MULT; A = 32'd100; B = 32'd100; Valid = 1'b1;
        @(negedge Clk);
        Valid = 1'b0;
        repeat (9) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        m_hilo = '0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("midrst_ready[bpc=%0d]", 1 << k), 64'(rdy[k]), 64'd1);
            chk($sformatf("midrst_hilo[bpc=%0d]", 1 << k), {hi[k], lo[k]}, 64'd0);
        end
        do_op(OP_MULT, 32'd2, 32'd3);
        for (int k = 0; k < 4; k++)
            chk($sformatf("post_rst_lo[bpc=%0d]", 1 << k), 64'(lo[k]), 64'd6);

        // Randomised mix against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
            sel = $urandom_range(0, 8);
            case (sel)
                0: do_op(OP_MULT,  ra, rb);
                1: do_op(OP_MULTU, ra, rb);
                2: do_op(OP_MADD,  ra, rb);
                3: do_op(OP_MSUB,  ra, rb);
                4: do_op(OP_MTHI,  ra, rb);
                5: do_op(OP_MTLO,  ra, rb);
                6: do_read(OP_MFHI);
                7: do_read(OP_MFLO);
                default: do_read(OP_BAD);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
